// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown driven by rising edges of an asynchronous 1 Hz input.
// Optional warn blink is enabled by defining WARN_BLINK_EN; otherwise warn is tied low.
module countdown_timer_bcd #(
  parameter logic [7:0] INIT_MIN = 8'h01,
  parameter logic [7:0] INIT_SEC = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk_in,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       warn
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t      state, state_next;
  logic        s1, s2, s3;
  logic        sec_tick;
  logic        ctl_start, ctl_pause;
  logic        count_zero;
  logic [15:0] dec;
  logic [7:0]  min_next, sec_next;
  logic        done_next;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second BCD decrement of MM:SS; 00:00 is returned unchanged.
  function automatic logic [15:0] dec_bcd(input logic [7:0] m, input logic [7:0] s);
    logic [7:0] mo;
    logic [7:0] so;
    mo = m;
    so = s;
    if (s[3:0] != 4'd0) begin
      so[3:0] = s[3:0] - 4'd1;
    end else if (s[7:4] != 4'd0) begin
      so[7:4] = s[7:4] - 4'd1;
      so[3:0] = 4'd9;
    end else if (m != 8'h00) begin
      so = 8'h59;
      if (m[3:0] != 4'd0) begin
        mo[3:0] = m[3:0] - 4'd1;
      end else begin
        mo[7:4] = m[7:4] - 4'd1;
        mo[3:0] = 4'd9;
      end
    end
    return {mo, so};
  endfunction

  assign sec_tick   = s2 & ~s3;
  assign ctl_start  = start & ~pause;
  assign ctl_pause  = pause & ~start;
  assign count_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
  assign dec        = dec_bcd(min_bcd, sec_bcd);

  always_comb begin
    state_next = state;
    min_next   = min_bcd;
    sec_next   = sec_bcd;
    done_next  = 1'b0;
    if (load) begin
      min_next   = {clamp_digit(load_min[7:4], 4'd9), clamp_digit(load_min[3:0], 4'd9)};
      sec_next   = {clamp_digit(load_sec[7:4], 4'd5), clamp_digit(load_sec[3:0], 4'd9)};
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ctl_start) begin
            if (count_zero) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (ctl_pause) state_next = PAUSE;
          // A tick coinciding with pause still counts; reaching zero wins over pause.
          if (sec_tick && !count_zero) begin
            min_next = dec[15:8];
            sec_next = dec[7:0];
            if (dec == 16'h0000) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (ctl_start) state_next = RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state   <= IDLE;
      min_bcd <= INIT_MIN;
      sec_bcd <= INIT_SEC;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      s1      <= slow_clk_in;
      s2      <= s1;
      s3      <= s2;
      state   <= state_next;
      min_bcd <= min_next;
      sec_bcd <= sec_next;
      running <= (state_next == RUN);
      expired <= (state_next == EXPIRED);
      done    <= done_next;
    end
  end

`ifdef WARN_BLINK_EN
  logic warn_next;

  // Blink follows the post-update count and state, so the tick reaching 00:10 is the first toggle.
  always_comb begin
    warn_next = 1'b0;
    if ((state_next == RUN || state_next == PAUSE) &&
        (min_next == 8'h00) && (sec_next <= 8'h10)) begin
      warn_next = sec_tick ? ~warn : warn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) warn <= 1'b0;
    else     warn <= warn_next;
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: vector table, directed corner sequences and random stimulus
// checked every cycle against a total-seconds reference model.
module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk_in = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, expired, done, warn;

  countdown_timer_bcd dut (
    .clk(clk), .rst(rst), .slow_clk_in(slow_clk_in), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .expired(expired),
    .done(done), .warn(warn)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  int chk_cnt = 0;
  int pass_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int       m_total = 90;
  int       m_state = M_IDLE;
  bit       m_done = 1'b0;
  bit       m_warn = 1'b0;
  bit [2:0] hist = 3'b000;

  function automatic logic [7:0] tobcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic int clamp_val(input logic [7:0] b, input int tmax);
    int t;
    int o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (t > tmax) t = tmax;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic bit tick_pending();
    return hist[1] & ~hist[2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  // Reference model: count held as total seconds, tick = sampled rise seen two edges late.
  task automatic model_edge();
    bit tick;
    tick = tick_pending();
    hist = {hist[1:0], slow_clk_in};
    if (rst) begin
      hist = 3'b000;
      m_total = 90;
      m_state = M_IDLE;
      m_done = 1'b0;
      m_warn = 1'b0;
    end else begin
      m_done = 1'b0;
      if (load) begin
        m_total = clamp_val(load_min, 9) * 60 + clamp_val(load_sec, 5);
        m_state = M_IDLE;
      end else begin
        case (m_state)
          M_IDLE: if (start && !pause) begin
            if (m_total > 0) m_state = M_RUN;
            else begin m_state = M_EXP; m_done = 1'b1; end
          end
          M_RUN: begin
            if (pause && !start) m_state = M_PAUSE;
            if (tick && m_total > 0) begin
              m_total = m_total - 1;
              if (m_total == 0) begin m_state = M_EXP; m_done = 1'b1; end
            end
          end
          M_PAUSE: if (start && !pause) m_state = M_RUN;
          default: ;
        endcase
      end
`ifdef WARN_BLINK_EN
      if ((m_state == M_RUN || m_state == M_PAUSE) && m_total <= 10) begin
        if (tick) m_warn = ~m_warn;
      end else begin
        m_warn = 1'b0;
      end
`else
      m_warn = 1'b0;
`endif
    end
  endtask

  task automatic step();
    logic [19:0] exp_v;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (done === 1'b1) done_cnt++;
    exp_v = {tobcd(m_total / 60), tobcd(m_total % 60), m_state == M_RUN, m_state == M_EXP, m_done, m_warn};
    chk("model", 32'({min_bcd, sec_bcd, running, expired, done, warn}), 32'(exp_v));
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(); pause = 1'b0;
  endtask

  task automatic rising_edges(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clk_in = 1'b1;
      repeat (4) step();
      slow_clk_in = 1'b0;
      repeat (4) step();
    end
  endtask

  // Raise the slow input and stop one cycle before the resulting tick is consumed.
  task automatic to_tick_edge();
    int k;
    slow_clk_in = 1'b0;
    repeat (4) step();
    slow_clk_in = 1'b1;
    k = 0;
    while (!tick_pending() && k < 10) begin
      step();
      k++;
    end
    chk("tick_wait_bound", 32'(k < 10), 32'd1);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] lm, ls;
    logic       st, pa;
    logic [7:0] em, es;
    logic       er, ee, ed;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 8'hAF, 8'h7C, 1'b0, 1'b0, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h99, 8'h59, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h99, 8'h59, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 8'h59, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h5A, 8'h6F, 1'b0, 1'b0, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0};

    // Reset held while the slow input toggles.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) slow_clk_in = ~slow_clk_in;
      step();
    end
    chk("rst_count", 32'({min_bcd, sec_bcd}), 32'h0130);
    chk("rst_flags", 32'({running, expired, done, warn}), 32'h0);
    rst = 1'b0;
    slow_clk_in = 1'b0;
    rising_edges(3);
    chk("idle_no_dec", 32'({min_bcd, sec_bcd, running}), 32'({16'h0130, 1'b0}));

    for (int i = 0; i < 14; i++) begin
      load = tbl[i].ld; load_min = tbl[i].lm; load_sec = tbl[i].ls;
      start = tbl[i].st; pause = tbl[i].pa;
      step();
      chk($sformatf("tbl%0d", i), 32'({min_bcd, sec_bcd, running, expired, done}),
          32'({tbl[i].em, tbl[i].es, tbl[i].er, tbl[i].ee, tbl[i].ed}));
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;

    // Minute borrow and full run down to expiry.
    do_load(8'h01, 8'h00);
    do_start();
    rising_edges(1);
    chk("borrow_0059", 32'({min_bcd, sec_bcd}), 32'h0059);
    done_cnt = 0;
    rising_edges(59);
    chk("expire_count", 32'({min_bcd, sec_bcd}), 32'h0000);
    chk("expire_done_once", 32'(done_cnt), 32'd1);
    chk("expire_flags", 32'({running, expired, done}), 32'b010);

    // Pause holds the count; pause with a coincident tick still decrements.
    do_load(8'h00, 8'h05);
    do_start();
    rising_edges(2);
    chk("pause_run2", 32'({min_bcd, sec_bcd}), 32'h0003);
    do_pause();
    rising_edges(3);
    chk("pause_hold", 32'({min_bcd, sec_bcd, running}), 32'({16'h0003, 1'b0}));
    do_start();
    rising_edges(1);
    chk("resume_dec", 32'({min_bcd, sec_bcd, running}), 32'({16'h0002, 1'b1}));
    to_tick_edge();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("pause_tick_dec", 32'({min_bcd, sec_bcd, running}), 32'({16'h0001, 1'b0}));
    slow_clk_in = 1'b0;
    rising_edges(1);
    chk("pause_tick_hold", 32'({min_bcd, sec_bcd}), 32'h0001);

    // Load wins over a coincident tick; expired ignores start.
    do_load(8'h00, 8'h30);
    do_start();
    to_tick_edge();
    load = 1'b1; load_min = 8'h00; load_sec = 8'h20;
    step();
    load = 1'b0;
    chk("load_prio", 32'({min_bcd, sec_bcd, running, expired}), 32'({16'h0020, 2'b00}));
    slow_clk_in = 1'b0;
    rising_edges(1);
    chk("load_prio_idle", 32'({min_bcd, sec_bcd}), 32'h0020);
    do_load(8'h00, 8'h00);
    do_start();
    do_start();
    chk("exp_ignore_start", 32'({min_bcd, sec_bcd, running, expired}), 32'({16'h0000, 2'b01}));
    do_load(8'h00, 8'h03);
    chk("exp_exit_load", 32'({min_bcd, sec_bcd, expired}), 32'({16'h0003, 1'b0}));

    // Warn blink window near the end of the count.
    do_load(8'h00, 8'h12);
    do_start();
    for (int i = 1; i <= 12; i++) begin
      int  s;
      bit  w;
      rising_edges(1);
      s = 12 - i;
      w = 1'b0;
`ifdef WARN_BLINK_EN
      if (s <= 10 && s > 0) w = (s % 2 == 0);
`endif
      chk($sformatf("warn_s%0d", s), 32'({sec_bcd, warn}), 32'({tobcd(s), w}));
    end

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 250) == 0;
      load  = ($urandom % 30) == 0;
      case ($urandom % 4)
        0: load_min = 8'h00;
        1: load_min = 8'h01;
        default: load_min = 8'($urandom);
      endcase
      load_sec = (($urandom % 3) == 0) ? 8'h05 : 8'($urandom);
      start = ($urandom % 8) == 0;
      pause = ($urandom % 10) == 0;
      if (($urandom % 3) == 0) slow_clk_in = ~slow_clk_in;
      step();
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
